// File: rtl/rom_arbiter.sv
// Two-port arbiter for a shared combinational-read ROM. It serves a fetch port and a
// data-constant port, and bounds fetch starvation of the data port with a burst counter.
module rom_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int FETCH_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // Data port
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    // Shared ROM
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    // Last-grant state, also usable as FSM debug view
    output logic [1:0]        owner
);

    // Handshake: a requester holds req/addr until it sees gnt in the same cycle;
    // req & gnt is the transfer, and the matching rvalid pulses exactly one cycle later.

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'b00,
        OWN_FETCH = 2'b01,
        OWN_DATA  = 2'b10
    } owner_e;

    owner_e            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic fetch_elig;
    logic data_elig;
    logic fetch_wins;
    logic if_gnt_c;
    logic dm_gnt_c;

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        fetch_elig = if_req & ~if_flush;
        data_elig  = dm_req;
        fetch_wins = (burst_q < 4'(FETCH_BURST));
        if_gnt_c   = 1'b0;
        dm_gnt_c   = 1'b0;
        if (rst_n) begin
            if (fetch_elig && (!data_elig || fetch_wins)) begin
                if_gnt_c = 1'b1;
            end else if (data_elig) begin
                dm_gnt_c = 1'b1;
            end
        end
    end

    assign if_gnt = if_gnt_c;
    assign dm_gnt = dm_gnt_c;

    // ROM address: the granted port drives it, otherwise the last granted address is replayed
    always_comb begin
        addr_d = addr_q;
        if (if_gnt_c) begin
            addr_d = if_addr;
        end else if (dm_gnt_c) begin
            addr_d = dm_addr;
        end
    end

    assign rom_addr = addr_d;

    // Burst counter only runs while the data port is actually waiting
    always_comb begin
        burst_d = burst_q;
        if (!dm_req || dm_gnt_c || if_flush) begin
            burst_d = 4'd0;
        end else if (if_gnt_c && (burst_q < 4'(FETCH_BURST))) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_comb begin
        if_rvalid_d = if_gnt_c;
        dm_rvalid_d = dm_gnt_c;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if (if_gnt_c) begin
            if_rdata_d = rom_data;
        end
        if (dm_gnt_c) begin
            dm_rdata_d = rom_data;
        end
    end

    always_comb begin
        state_d = OWN_IDLE;
        if (if_gnt_c) begin
            state_d = OWN_FETCH;
        end else if (dm_gnt_c) begin
            state_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OWN_IDLE;
            burst_q     <= 4'd0;
            addr_q      <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign owner     = state_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: table-driven vectors, hand sequences for contention, flush and
// reset corners, and a random phase; read data is scored through expected queues.
module tb_rom_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int FB     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req, if_flush, dm_req;
    logic [ADDR_W-1:0] if_addr, dm_addr;
    logic              if_gnt, dm_gnt, if_rvalid, dm_rvalid;
    logic [DATA_W-1:0] if_rdata, dm_rdata, rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        owner;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_BURST(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    typedef struct {
        logic              rst_n;
        logic              if_req;
        logic              if_flush;
        logic [ADDR_W-1:0] if_addr;
        logic              dm_req;
        logic [ADDR_W-1:0] dm_addr;
        logic              exp_ig;
        logic              exp_dg;
    } vec_t;

    vec_t vecs[13];

    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] dm_exp_q[$];
    logic [DATA_W-1:0] if_rdata_m, dm_rdata_m;
    logic [ADDR_W-1:0] held_m;
    logic              addr_known = 1'b0;
    int                burst_m = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    function automatic vec_t mk(input logic r, input logic ir, input logic fl,
                                input logic [ADDR_W-1:0] ia, input logic dr,
                                input logic [ADDR_W-1:0] da, input logic eig,
                                input logic edg);
        vec_t v;
        v.rst_n = r; v.if_req = ir; v.if_flush = fl; v.if_addr = ia;
        v.dm_req = dr; v.dm_addr = da; v.exp_ig = eig; v.exp_dg = edg;
        return v;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // One clock cycle: drive, check grant-cycle outputs, then check registered outputs
    task automatic cycle(input vec_t v, input string tag);
        logic [ADDR_W-1:0] exp_addr;
        logic [1:0]        exp_owner;
        logic [DATA_W-1:0] popped;
        rst_n = v.rst_n; if_req = v.if_req; if_flush = v.if_flush; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_addr = v.dm_addr;
        #2;
        check({tag, " if_gnt"}, 32'(if_gnt), 32'(v.exp_ig));
        check({tag, " dm_gnt"}, 32'(dm_gnt), 32'(v.exp_dg));
        exp_addr = v.exp_ig ? v.if_addr : (v.exp_dg ? v.dm_addr : held_m);
        if (v.exp_ig || v.exp_dg || addr_known)
            check({tag, " rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        if (v.exp_ig) if_exp_q.push_back(rom_fn(v.if_addr));
        if (v.exp_dg) dm_exp_q.push_back(rom_fn(v.dm_addr));
        @(posedge clk);
        #1;
        if (!v.rst_n) begin
            held_m = '0; addr_known = 1'b1; if_rdata_m = '0; dm_rdata_m = '0;
            burst_m = 0; exp_owner = 2'b00;
            if_exp_q.delete(); dm_exp_q.delete();
        end else begin
            if (v.exp_ig || v.exp_dg) begin
                held_m = exp_addr; addr_known = 1'b1;
            end
            exp_owner = v.exp_ig ? 2'b01 : (v.exp_dg ? 2'b10 : 2'b00);
            if (!v.dm_req || v.exp_dg || v.if_flush) burst_m = 0;
            else if (v.exp_ig && burst_m < FB) burst_m++;
        end
        check({tag, " if_rvalid"}, 32'(if_rvalid), 32'(v.exp_ig && v.rst_n));
        check({tag, " dm_rvalid"}, 32'(dm_rvalid), 32'(v.exp_dg && v.rst_n));
        if (if_exp_q.size() > 0) begin
            popped = if_exp_q.pop_front();
            if (v.rst_n) if_rdata_m = popped;
        end
        if (dm_exp_q.size() > 0) begin
            popped = dm_exp_q.pop_front();
            if (v.rst_n) dm_rdata_m = popped;
        end
        check({tag, " if_rdata"}, if_rdata, if_rdata_m);
        check({tag, " dm_rdata"}, dm_rdata, dm_rdata_m);
        check({tag, " owner"}, 32'(owner), 32'(exp_owner));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic ig, dg, fe;
        //                 rst ir fl if_addr   dr dm_addr   ig dg
        vecs[0]  = mk(1'b1, 1, 0, 10'h000, 0, 10'h000, 1, 0);
        vecs[1]  = mk(1'b1, 1, 0, 10'h001, 0, 10'h000, 1, 0);
        vecs[2]  = mk(1'b1, 1, 0, 10'h002, 0, 10'h000, 1, 0);
        vecs[3]  = mk(1'b1, 0, 0, 10'h0AA, 0, 10'h0BB, 0, 0);
        vecs[4]  = mk(1'b1, 0, 0, 10'h000, 1, 10'h010, 0, 1);
        vecs[5]  = mk(1'b1, 1, 1, 10'h005, 0, 10'h000, 0, 0);
        vecs[6]  = mk(1'b1, 1, 1, 10'h006, 1, 10'h020, 0, 1);
        vecs[7]  = mk(1'b1, 1, 0, 10'h3FF, 0, 10'h000, 1, 0);
        vecs[8]  = mk(1'b1, 0, 0, 10'h123, 0, 10'h234, 0, 0);
        vecs[9]  = mk(1'b1, 0, 0, 10'h001, 0, 10'h002, 0, 0);
        vecs[10] = mk(1'b1, 1, 0, 10'h3FF, 1, 10'h000, 1, 0);
        vecs[11] = mk(1'b1, 0, 0, 10'h000, 1, 10'h3FF, 0, 1);
        vecs[12] = mk(1'b1, 0, 0, 10'h155, 0, 10'h2AA, 0, 0);

        rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0;
        if_addr = '0; dm_addr = '0;
        @(posedge clk);
        #1;
        // Reset held with both ports requesting: no grants, no responses
        cycle(mk(1'b0, 1, 0, 10'h011, 1, 10'h022, 0, 0), "reset0");
        cycle(mk(1'b0, 1, 0, 10'h033, 1, 10'h044, 0, 0), "reset1");

        for (int i = 0; i < 13; i++) cycle(vecs[i], $sformatf("vec%0d", i));

        // Contention: F,F,F,F,D repeating
        for (int i = 0; i < 10; i++)
            cycle(mk(1'b1, 1, 0, ADDR_W'(i), 1, ADDR_W'(10'h100 + i),
                     (i % 5) != 4, (i % 5) == 4), $sformatf("cont%0d", i));

        // Flush while both request: data wins, then a fresh full fetch burst
        cycle(mk(1'b1, 1, 0, 10'h050, 1, 10'h200, 1, 0), "flush_a");
        cycle(mk(1'b1, 1, 0, 10'h051, 1, 10'h200, 1, 0), "flush_b");
        cycle(mk(1'b1, 1, 1, 10'h052, 1, 10'h200, 0, 1), "flush_c");
        for (int i = 0; i < 5; i++)
            cycle(mk(1'b1, 1, 0, ADDR_W'(10'h060 + i), 1, 10'h201, i != 4, i == 4),
                  $sformatf("post_flush%0d", i));

        // Reset pulse in the middle of back-to-back fetches
        cycle(mk(1'b1, 1, 0, 10'h040, 0, 10'h000, 1, 0), "rstmid_a");
        cycle(mk(1'b1, 1, 0, 10'h041, 0, 10'h000, 1, 0), "rstmid_b");
        cycle(mk(1'b0, 1, 0, 10'h042, 1, 10'h300, 0, 0), "rstmid_c");
        cycle(mk(1'b1, 1, 0, 10'h042, 0, 10'h000, 1, 0), "rstmid_d");
        cycle(mk(1'b1, 0, 0, 10'h000, 1, 10'h301, 0, 1), "rstmid_e");

        // Random traffic against a reference arbitration model
        for (int i = 0; i < 80; i++) begin
            v = mk(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ADDR_W'($urandom_range(0, 1023)),
                   1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 1023)), 0, 0);
            fe = v.if_req && !v.if_flush;
            ig = v.rst_n && fe && (!v.dm_req || burst_m < FB);
            dg = v.rst_n && !ig && v.dm_req;
            v.exp_ig = ig; v.exp_dg = dg;
            cycle(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, ROM word-address width.
REQ-002 Parameter DATA_W, default 32, ROM word width.
REQ-003 Parameter FETCH_BURST, default 4, max consecutive fetch grants while a data request waits (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 if_req  input  1  fetch-port read request.
REQ-007 if_addr  input  ADDR_W  fetch-port word address.
REQ-008 if_flush  input  1  fetch-port flush (branch/jump redirect).
REQ-009 if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-010 if_rvalid  output  1  fetch read data valid (registered).
REQ-011 if_rdata  output  DATA_W  fetch read data (registered).
REQ-012 dm_req  input  1  data-port read request (constant-table loads from code space).
REQ-013 dm_addr  input  ADDR_W  data-port word address.
REQ-014 dm_gnt  output  1  data request accepted this cycle (combinational).
REQ-015 dm_rvalid  output  1  data read data valid (registered).
REQ-016 dm_rdata  output  DATA_W  data read data (registered).
REQ-017 rom_addr  output  ADDR_W  address to the shared combinational-read ROM.
REQ-018 rom_data  input  DATA_W  ROM read data, valid same cycle as rom_addr.
REQ-019 owner  output  2  last-grant state: 00 IDLE, 01 FETCH, 10 DATA (registered).

Function
REQ-020 Block SHALL issue at most one grant per cycle; if_gnt and dm_gnt never both 1.
REQ-021 Requester SHALL hold req and addr stable until its gnt; block SHALL NOT buffer ungranted requests.
REQ-022 Fetch eligible = if_req & ~if_flush; data eligible = dm_req.
REQ-023 Only one eligible: that port granted.
REQ-024 Both eligible: fetch granted while burst_cnt < FETCH_BURST; else data granted.
REQ-025 burst_cnt (4 bits): +1 on a fetch grant with dm_req=1; cleared on a data grant, or any cycle with dm_req=0; saturates at FETCH_BURST.
REQ-026 rom_addr = granted port's address in grant cycle; with no grant, rom_addr = last granted address (held register).
REQ-027 Read latency 1 cycle: grant at cycle t -> rvalid=1 at cycle t+1 with rdata = rom_data sampled at end of t.
REQ-028 rvalid is a one-cycle pulse per grant; back-to-back grants give back-to-back rvalid (throughput 1 word/cycle).
REQ-029 rdata of a port SHALL hold its last value when that port's rvalid=0.
REQ-030 if_flush=1 at cycle t: if_gnt=0 at t; if_rvalid at t+1 forced 0 even if fetch granted at t-1's response is already delivered at t (no retroactive cancel); burst_cnt cleared.
REQ-031 owner FSM: next = FETCH on fetch grant, DATA on data grant, IDLE on no grant.
REQ-032 Address wrap: addresses are word indices 0..2^ADDR_W-1; no range check; all-ones address passes unchanged.

Reset
REQ-033 While rst_n=0 at a rising edge: if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, burst_cnt=0, held rom_addr=0, owner=IDLE.
REQ-034 While rst_n=0, if_gnt=0 and dm_gnt=0 regardless of requests; grants from the cycle reset asserts produce no rvalid.
REQ-035 First grant possible in first cycle with rst_n=1.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0,1,2 on consecutive cycles -> if_gnt=1 each cycle, if_rvalid=1 cycles 2-4 with ROM words 0,1,2.
REQ-037 Contention, FETCH_BURST=4: if_req and dm_req held 1 -> grants F,F,F,F,D,F,F,F,F,D; dm_rdata = ROM[dm_addr] one cycle after each D.
REQ-038 Flush: both requesting, if_flush=1 one cycle -> dm_gnt=1 that cycle, burst_cnt=0 afterwards, if_rvalid=0 the following cycle.
REQ-039 Idle hold: grant addr 0x3FF then drop all requests -> rom_addr stays 0x3FF, owner=IDLE, rvalid=0, rdata unchanged.
REQ-040 Reset mid-stream: rst_n=0 one cycle during back-to-back fetch -> next cycle all rvalid=0, rdata=0, owner=IDLE; granting resumes after release.
